// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: shares one single-port synchronous 32x8 RAM between two requesters, A and B.
// Each transaction is three cycles long: grant (command on the RAM pins), issue (RAM samples the
// command), wait (registered RAM read data returned with done).
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata requester A command (held until a_gnt)
//   a_gnt, a_done, a_rdata    A accepted / completed pulses, last read data for A
//   b_*                       same set for requester B
//   ram_write_enable, ram_address, ram_data_in   command to the RAM (this block is sole driver)
//   ram_data_out              RAM read data, one-cycle registered latency
//
// Build option: define ARB_FIXED_PRIORITY_EN to make A win every tie (B may starve while A keeps
// requesting). Without it ties are broken round-robin.
module ram_arbiter_2p #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_done,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_done,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e state_q, state_d;

    logic owner_b_q, owner_b_d;  // 1: current transaction belongs to B
    logic op_we_q, op_we_d;

    logic                  a_gnt_d, b_gnt_d, a_done_d, b_done_d;
    logic [DATA_WIDTH-1:0] a_rdata_d, b_rdata_d;
    logic                  ram_write_enable_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_in_d;

    logic                  any_req, pick_b, tie_pick_b;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

`ifdef ARB_FIXED_PRIORITY_EN
    assign tie_pick_b = 1'b0;
`else
    // Remembers the last winner; the other requester takes the next tie.
    logic last_b_q, last_b_d;

    assign tie_pick_b = ~last_b_q;

    always_comb begin
        last_b_d = last_b_q;
        if (state_q == StIdle && any_req) begin
            last_b_d = pick_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    // Arbitration and command selection.
    always_comb begin
        any_req   = a_req | b_req;
        pick_b    = (a_req & b_req) ? tie_pick_b : b_req;
        cmd_we    = pick_b ? b_we : a_we;
        cmd_addr  = pick_b ? b_addr : a_addr;
        cmd_wdata = pick_b ? b_wdata : a_wdata;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        a_gnt_d            = 1'b0;
        b_gnt_d            = 1'b0;
        a_done_d           = 1'b0;
        b_done_d           = 1'b0;
        a_rdata_d          = a_rdata;
        b_rdata_d          = b_rdata;
        ram_write_enable_d = 1'b0;
        ram_address_d      = ram_address;
        ram_data_in_d      = ram_data_in;
        owner_b_d          = owner_b_q;
        op_we_d            = op_we_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    a_gnt_d            = ~pick_b;
                    b_gnt_d            = pick_b;
                    owner_b_d          = pick_b;
                    op_we_d            = cmd_we;
                    ram_write_enable_d = cmd_we;
                    ram_address_d      = cmd_addr;
                    ram_data_in_d      = cmd_wdata;
                end
            end
            StIssue: begin
                // Address and data hold so the RAM sees a stable command at this edge.
            end
            StWait: begin
                a_done_d = ~owner_b_q;
                b_done_d = owner_b_q;
                if (!op_we_q) begin
                    if (owner_b_q) begin
                        b_rdata_d = ram_data_out;
                    end else begin
                        a_rdata_d = ram_data_out;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            owner_b_q        <= 1'b0;
            op_we_q          <= 1'b0;
            a_gnt            <= 1'b0;
            b_gnt            <= 1'b0;
            a_done           <= 1'b0;
            b_done           <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
        end else begin
            state_q          <= state_d;
            owner_b_q        <= owner_b_d;
            op_we_q          <= op_we_d;
            a_gnt            <= a_gnt_d;
            b_gnt            <= b_gnt_d;
            a_done           <= a_done_d;
            b_done           <= b_done_d;
            a_rdata          <= a_rdata_d;
            b_rdata          <= b_rdata_d;
            ram_write_enable <= ram_write_enable_d;
            ram_address      <= ram_address_d;
            ram_data_in      <= ram_data_in_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: attaches a behavioural 32x8 RAM and compares every output each cycle
// against a transaction-level reference (grant edge, fixed edge offsets, plain memory array).
module tb_ram_arbiter_2p;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FixedPriority = 1'b1;
`else
    localparam bit FixedPriority = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_done, b_gnt, b_done;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic [DW-1:0] ram_mem [32] = '{default: '0};

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    ram_arbiter_2p #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .a_req           (a_req),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .a_gnt           (a_gnt),
        .a_done          (a_done),
        .a_rdata         (a_rdata),
        .b_req           (b_req),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .b_gnt           (b_gnt),
        .b_done          (b_done),
        .b_rdata         (b_rdata),
        .ram_write_enable(ram_write_enable),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out)
    );

    // Single-port RAM, registered read returning the pre-write contents.
    always @(posedge clock) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    // Reference model: one transaction in flight, timed from its grant edge.
    int            k = 0;
    int            m_g = 0;
    bit            m_busy = 1'b0, m_owner_b = 1'b0, m_we = 1'b0, m_last_b = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd = '0;
    logic [DW-1:0] m_mem [32] = '{default: '0};
    logic          e_a_gnt = 1'b0, e_a_done = 1'b0, e_b_gnt = 1'b0, e_b_done = 1'b0;
    logic [DW-1:0] e_a_rdata = '0, e_b_rdata = '0, e_din = '0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;

    logic [33:0] dut_vec, exp_vec;
    assign dut_vec = {a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata,
                      ram_write_enable, ram_address, ram_data_in};
    assign exp_vec = {e_a_gnt, e_a_done, e_a_rdata, e_b_gnt, e_b_done, e_b_rdata,
                      e_we, e_addr, e_din};

    task automatic model_edge();
        bit pick_b;
        k++;
        // The RAM samples the command on the edge after the grant, even if reset is high.
        if (m_busy && k == m_g + 1) begin
            m_rd = m_mem[m_addr];
            if (m_we) m_mem[m_addr] = m_wdata;
        end
        e_a_gnt = 1'b0; e_b_gnt = 1'b0; e_a_done = 1'b0; e_b_done = 1'b0; e_we = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_last_b = 1'b1;
            e_a_rdata = '0; e_b_rdata = '0; e_addr = '0; e_din = '0;
        end else if (m_busy) begin
            if (k == m_g + 2) begin
                m_busy = 1'b0;
                if (m_owner_b) begin
                    e_b_done = 1'b1;
                    if (!m_we) e_b_rdata = m_rd;
                end else begin
                    e_a_done = 1'b1;
                    if (!m_we) e_a_rdata = m_rd;
                end
            end
        end else if (a_req || b_req) begin
            pick_b = (a_req && b_req) ? (FixedPriority ? 1'b0 : !m_last_b) : b_req;
            m_busy = 1'b1; m_g = k; m_owner_b = pick_b; m_last_b = pick_b;
            m_we = pick_b ? b_we : a_we;
            m_addr = pick_b ? b_addr : a_addr;
            m_wdata = pick_b ? b_wdata : a_wdata;
            e_a_gnt = !pick_b; e_b_gnt = pick_b;
            e_we = m_we; e_addr = m_addr; e_din = m_wdata;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic rand_a();
        a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom); a_wdata = DW'($urandom);
    endtask

    task automatic rand_b();
        b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom); b_wdata = DW'($urandom);
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; b_req = 1'b0; rand_a(); rand_b();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'($urandom_range(0, 1)); b_req = 1'($urandom_range(0, 1));
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_model k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            vectors++;
            if (dut_vec !== 34'd0) begin
                miscompares++;
                $display("FAIL reset_zero k=%0d got=%h want=0", k, dut_vec);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_a_write_read();
        logic [2:0] pat;
        idle_inputs();
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 8'hAA;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) a_req = 1'b0;
            pat = (c == 1) ? 3'b110 : ((c == 3) ? 3'b001 : 3'b000);
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL a_write k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            vectors++;
            if ({a_gnt, ram_write_enable, a_done} !== pat) begin
                miscompares++;
                $display("FAIL a_write_timing c=%0d got=%b want=%b", c,
                         {a_gnt, ram_write_enable, a_done}, pat);
            end
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) a_req = 1'b0;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL a_read k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            vectors++;
            if ({b_gnt, b_done, b_rdata} !== 10'd0) begin
                miscompares++;
                $display("FAIL b_quiet c=%0d got=%h want=0", c, {b_gnt, b_done, b_rdata});
            end
        end
        vectors++;
        if ({a_done, a_rdata} !== {1'b1, 8'hAA}) begin
            miscompares++;
            $display("FAIL a_read_data got=%h want=1aa", {a_done, a_rdata});
        end
    endtask

    task automatic test_tie();
        int ga, gb;
        logic [DW-1:0] b_seen;
        reset = 1'b1; idle_inputs();
        tick();
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd1; a_wdata = 8'h55;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd1;
        ga = 0; gb = 0; b_seen = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL tie k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            if (a_gnt) begin ga = c; a_req = 1'b0; end
            if (b_gnt) begin gb = c; b_req = 1'b0; end
            if (b_done) b_seen = b_rdata;
        end
        vectors++;
        if (ga != 1 || gb != 4) begin
            miscompares++;
            $display("FAIL tie_order got a@%0d b@%0d want a@1 b@4", ga, gb);
        end
        vectors++;
        if (b_seen !== 8'h55) begin
            miscompares++;
            $display("FAIL tie_b_rdata got=%h want=55", b_seen);
        end
    endtask

    task automatic test_round_robin();
        int seq[$];
        int want;
        reset = 1'b1; idle_inputs();
        tick();
        reset = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rr k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            if (a_gnt) begin seq.push_back(0); rand_a(); end
            if (b_gnt) begin seq.push_back(1); rand_b(); end
        end
        a_req = 1'b0; b_req = 1'b0;
        vectors++;
        if (seq.size() != 4) begin
            miscompares++;
            $display("FAIL rr_count got=%0d want=4", seq.size());
        end
        for (int i = 0; i < 4; i++) begin
            want = FixedPriority ? 0 : (i % 2);
            vectors++;
            if (i >= seq.size() || seq[i] != want) begin
                miscompares++;
                $display("FAIL rr_order i=%0d got=%0d want=%0d", i,
                         (i < seq.size()) ? seq[i] : -1, want);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] a_keep;
        a_keep = e_a_rdata;
        idle_inputs();
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd31; b_wdata = 8'hFF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) b_req = 1'b0;
            if (c == 3) begin b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31; end
            if (c == 4) b_req = 1'b0;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL wrap k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
        end
        vectors++;
        if ({b_done, b_rdata, a_rdata} !== {1'b1, 8'hFF, a_keep}) begin
            miscompares++;
            $display("FAIL wrap_data got=%h want=%h", {b_done, b_rdata, a_rdata},
                     {1'b1, 8'hFF, a_keep});
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd2; a_wdata = 8'h12;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin a_req = 1'b0; reset = 1'b1; end
            if (c == 2) reset = 1'b0;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rst_mid k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            vectors++;
            if (c >= 2 && (dut_vec !== 34'd0)) begin
                miscompares++;
                $display("FAIL rst_mid_quiet c=%0d got=%h want=0", c, dut_vec);
            end
        end
        // The RAM already latched the write on the edge the reset was sampled.
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd2;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) a_req = 1'b0;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rst_mid_read k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
        end
        vectors++;
        if ({a_done, a_rdata} !== {1'b1, 8'h12}) begin
            miscompares++;
            $display("FAIL rst_mid_data got=%h want=112", {a_done, a_rdata});
        end
    endtask

    task automatic test_pulse();
        idle_inputs();
        for (int pass = 0; pass < 2; pass++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = AW'($urandom);
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c == 1) b_req = 1'b0;
                if (c == 2) a_req = 1'b1;
                if (c == 3 && pass == 0) a_req = 1'b0;
                if (c == 4) a_req = 1'b0;
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL pulse k=%0d got=%h want=%h", k, dut_vec, exp_vec);
                end
                vectors++;
                if (a_gnt !== (pass == 1 && c == 4)) begin
                    miscompares++;
                    $display("FAIL pulse_gnt pass=%0d c=%0d got=%b", pass, c, a_gnt);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL pulse_tail k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            a_req = 1'($urandom_range(0, 1)); b_req = 1'($urandom_range(0, 1));
            rand_a(); rand_b();
            tick();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random k=%0d got=%h want=%h", k, dut_vec, exp_vec);
            end
            vectors++;
            if ((a_gnt && b_gnt) || (a_done && b_done)) begin
                miscompares++;
                $display("FAIL random_excl k=%0d gnt=%b%b done=%b%b", k, a_gnt, b_gnt,
                         a_done, b_done);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_a_write_read();
        test_tie();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
